// File: rtl/fifo_frame_reader.sv
// Drains the ADC sample-byte FIFO and emits framed packets on a valid/ready byte stream:
// HDR0 HDR1, PAYLOAD_LEN payload bytes, 8-bit additive checksum.
module fifo_frame_reader #(
  parameter int unsigned PAYLOAD_LEN = 256,
  parameter int unsigned RD_LATENCY  = 2,
  parameter logic [7:0]  HDR0        = 8'hEB,
  parameter logic [7:0]  HDR1        = 8'h90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sop,
  output logic        m_eop,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CNT_W      = 17;
  localparam int unsigned SKID_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned OCC_W      = 3;
  localparam logic [CNT_W-1:0] LEN    = CNT_W'(PAYLOAD_LEN);
  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {IDLE, HDR_A, HDR_B, PAYLOAD, CKSUM} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [7:0]       csum_q, csum_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic [RD_LATENCY-1:0] pipe_q;
  logic [7:0]       skid_q [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] inflight_c;
  logic             tail_v, occ_nz, head_v;
  logic [7:0]       head_data;
  logic             fetch_state, rd_en_c, pop_c, buf_pop, buf_wr;
  logic             m_valid_c, m_sop_c, m_eop_c;
  logic [7:0]       m_data_c;

  // Reads still travelling through the FIFO output pipeline.
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight_c = inflight_c + OCC_W'(pipe_q[i]);
  end

  // Arriving FIFO data falls straight through when the buffer is empty, so payload follows the header gap-free.
  assign tail_v    = pipe_q[RD_LATENCY-1];
  assign occ_nz    = (occ_q != '0);
  assign head_v    = occ_nz || tail_v;
  assign head_data = occ_nz ? skid_q[rd_ptr_q] : fifo_rd_data;

  assign fetch_state = (state_q == HDR_A) || (state_q == HDR_B) || (state_q == PAYLOAD);
  assign rd_en_c = fetch_state && !fifo_empty && (issued_q < LEN) &&
                   (({1'b0, occ_q} + {1'b0, inflight_c}) < 4'd4);

  assign buf_pop = pop_c && occ_nz;
  assign buf_wr  = tail_v && !(pop_c && !occ_nz);
  assign occ_d   = occ_q + OCC_W'(buf_wr) - OCC_W'(buf_pop);

  // Next-state and stream outputs.
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q + CNT_W'(rd_en_c);
    sent_d       = sent_q;
    csum_d       = csum_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    pop_c        = 1'b0;
    m_valid_c    = 1'b0;
    m_data_c     = 8'h00;
    m_sop_c      = 1'b0;
    m_eop_c      = 1'b0;
    case (state_q)
      IDLE: begin
        issued_d = '0;
        sent_d   = '0;
        csum_d   = 8'h00;
        if (!fifo_empty) state_d = HDR_A;
      end
      HDR_A: begin
        m_valid_c = 1'b1;
        m_data_c  = HDR0;
        m_sop_c   = 1'b1;
        if (m_ready) state_d = HDR_B;
      end
      HDR_B: begin
        m_valid_c = 1'b1;
        m_data_c  = HDR1;
        if (m_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        m_valid_c = head_v;
        m_data_c  = head_v ? head_data : 8'h00;
        if (head_v && m_ready) begin
          pop_c  = 1'b1;
          csum_d = csum_q + head_data;
          sent_d = sent_q + CNT_W'(1);
          if (sent_q == LEN_M1) state_d = CKSUM;
        end
      end
      CKSUM: begin
        m_valid_c = 1'b1;
        m_data_c  = csum_q;
        m_eop_c   = 1'b1;
        if (m_ready) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      issued_q     <= '0;
      sent_q       <= '0;
      csum_q       <= 8'h00;
      frame_cnt_q  <= 16'h0000;
      frame_done_q <= 1'b0;
      pipe_q       <= '0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      sent_q       <= sent_d;
      csum_q       <= csum_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      pipe_q       <= (pipe_q << 1) | RD_LATENCY'(rd_en_c);
    end
  end

  // Skid buffer; the issue limit keeps occupancy plus in-flight reads within its depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_q[i] <= 8'h00;
    end else begin
      if (buf_wr && !buf_pop) assert (occ_q < OCC_W'(SKID_DEPTH));
      if (buf_wr) begin
        skid_q[wr_ptr_q] <= fifo_rd_data;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (buf_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  assign fifo_rd_en = rd_en_c;
  assign m_valid    = m_valid_c;
  assign m_data     = m_data_c;
  assign m_sop      = m_sop_c;
  assign m_eop      = m_eop_c;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
